smbus_ioexp_regs: RTL

//  Register bank and GPIO core of the SMBus I/O expander. It sits directly downstream of the
//  I2C slave and consumes its offset, write-data, WRITE_EN and READ_EN strobes. It returns

---
 rtl/ioexp_pkg.sv | 19 +
 rtl/ioexp_in_filter.sv | 65 ++++++
 rtl/smbus_ioexp_regs.sv | 114 +++++++++++
 3 files changed

// File: rtl/ioexp_pkg.sv
// Shared definitions for the SMBus I/O expander: register offsets and small helpers.
package ioexp_pkg;

  localparam logic [7:0] REG_IN0     = 8'h00;
  localparam logic [7:0] REG_IN1     = 8'h01;
  localparam logic [7:0] REG_OUT0    = 8'h02;
  localparam logic [7:0] REG_OUT1    = 8'h03;
  localparam logic [7:0] REG_POL0    = 8'h04;
  localparam logic [7:0] REG_POL1    = 8'h05;
  localparam logic [7:0] REG_CFG0    = 8'h06;
  localparam logic [7:0] REG_CFG1    = 8'h07;
  localparam logic [7:0] INVALID_OFS = 8'hFF;

  // Expand the per-port arm bits to a 16-bit pin mask {port1, port0}.
  function automatic logic [15:0] port_mask(input logic [1:0] arm);
    return {{8{arm[1]}}, {8{arm[0]}}};
  endfunction

endpackage

// File: rtl/ioexp_in_filter.sv
// GPIO input conditioning: multi-stage synchronizer followed by per-bit debounce.
module ioexp_in_filter #(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DEB_CYC     = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pins,
  output logic [WIDTH-1:0] filt,
  output logic [WIDTH-1:0] filt_next
);

  // Counter is at least one bit wide so the bypass configuration still elaborates.
  localparam int unsigned CW = (DEB_CYC == 0) ? 1 : $clog2(DEB_CYC + 1);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync;
  logic [CW-1:0]    cnt_q  [WIDTH];
  logic [CW-1:0]    cnt_d  [WIDTH];
  logic [WIDTH-1:0] filt_q, filt_d;

  assign sync      = sync_q[SYNC_STAGES-1];
  assign filt      = filt_q;
  assign filt_next = filt_d;

  // Synchronizer shift chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= pins;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  // Debounce: a bit must differ from filt for DEB_CYC consecutive clocks to be accepted.
  always_comb begin
    filt_d = filt_q;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      if (DEB_CYC == 0) begin
        filt_d[i] = sync[i];
      end else if (sync[i] != filt_q[i]) begin
        if (cnt_q[i] == CW'(DEB_CYC - 1)) begin
          filt_d[i] = sync[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
  end

  // Filter state and counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      filt_q <= '0;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
    end else begin
      filt_q <= filt_d;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
    end
  end

endmodule

// File: rtl/smbus_ioexp_regs.sv
// Register bank and GPIO core of the SMBus I/O expander (PCA9555-style map).
module smbus_ioexp_regs
  import ioexp_pkg::*;
#(
  parameter logic [15:0] OUT_RST     = 16'hFFFF,
  parameter logic [15:0] POL_RST     = 16'h0000,
  parameter logic [15:0] CFG_RST     = 16'hFFFF,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DEB_CYC     = 4
) (
  input  logic        CLK_IN,
  input  logic        RESET,
  input  logic [7:0]  I2C_OFFSET,
  input  logic [7:0]  I2C_WDATA,
  input  logic        I2C_WRITE_EN,
  input  logic        I2C_READ_EN,
  output logic [7:0]  I2C_RDATA,
  input  logic [15:0] GPIO_IN,
  output logic [15:0] GPIO_OUT,
  output logic [15:0] GPIO_OE,
  output logic        INT_N
);

  logic [15:0] out_q, pol_q, cfg_q;
  logic [15:0] snap_q;
  logic [1:0]  arm_q;
  logic [7:0]  rdata_q;
  logic        int_n_q;
  logic [15:0] filt, filt_next;
  logic [15:0] in_val;
  logic [7:0]  rd_val;

  ioexp_in_filter #(
    .WIDTH       (16),
    .SYNC_STAGES (SYNC_STAGES),
    .DEB_CYC     (DEB_CYC)
  ) u_in_filter (
    .clk       (CLK_IN),
    .rst       (RESET),
    .pins      (GPIO_IN),
    .filt      (filt),
    .filt_next (filt_next)
  );

  assign in_val    = filt ^ pol_q;
  assign GPIO_OUT  = out_q;
  assign GPIO_OE   = ~cfg_q;
  assign I2C_RDATA = rdata_q;
  assign INT_N     = int_n_q;

  // RW register writes; input ports and unmapped offsets are ignored.
  always_ff @(posedge CLK_IN or posedge RESET) begin
    if (RESET) begin
      out_q <= OUT_RST;
      pol_q <= POL_RST;
      cfg_q <= CFG_RST;
    end else if (I2C_WRITE_EN) begin
      case (I2C_OFFSET)
        REG_OUT0: out_q[7:0]  <= I2C_WDATA;
        REG_OUT1: out_q[15:8] <= I2C_WDATA;
        REG_POL0: pol_q[7:0]  <= I2C_WDATA;
        REG_POL1: pol_q[15:8] <= I2C_WDATA;
        REG_CFG0: cfg_q[7:0]  <= I2C_WDATA;
        REG_CFG1: cfg_q[15:8] <= I2C_WDATA;
        default:  ;
      endcase
    end
  end

  // Read mux over the register map.
  always_comb begin
    rd_val = 8'hFF;
    case (I2C_OFFSET)
      REG_IN0:  rd_val = in_val[7:0];
      REG_IN1:  rd_val = in_val[15:8];
      REG_OUT0: rd_val = out_q[7:0];
      REG_OUT1: rd_val = out_q[15:8];
      REG_POL0: rd_val = pol_q[7:0];
      REG_POL1: rd_val = pol_q[15:8];
      REG_CFG0: rd_val = cfg_q[7:0];
      REG_CFG1: rd_val = cfg_q[15:8];
      default:  rd_val = 8'hFF;
    endcase
  end

  // Read data capture; input-port reads also take the interrupt snapshot and arm the port.
  // Snapshot uses filt_next so a change landing on the read edge raises no interrupt.
  always_ff @(posedge CLK_IN or posedge RESET) begin
    if (RESET) begin
      rdata_q <= 8'hFF;
      snap_q  <= '0;
      arm_q   <= '0;
    end else if (I2C_READ_EN) begin
      rdata_q <= rd_val;
      if (I2C_OFFSET == REG_IN0) begin
        snap_q[7:0] <= filt_next[7:0];
        arm_q[0]    <= 1'b1;
      end else if (I2C_OFFSET == REG_IN1) begin
        snap_q[15:8] <= filt_next[15:8];
        arm_q[1]     <= 1'b1;
      end
    end
  end

  // Registered interrupt: armed input pins whose filtered value left the snapshot.
  always_ff @(posedge CLK_IN or posedge RESET) begin
    if (RESET) begin
      int_n_q <= 1'b1;
    end else begin
      int_n_q <= ~|(((filt ^ snap_q) & cfg_q) & port_mask(arm_q));
    end
  end

endmodule
